// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle multiply/divide unit for the X stage:
// decode, start pulse, stall until result or timeout, then one writeback request.
module multdiv_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int EXC_MUL = 4,
    parameter int EXC_DIV = 5,
    parameter int EXC_TMO = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir_x,
    input  logic        valid_x,
    input  logic        flush,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] RSTATUS = 5'd30;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        isDiv_q, isDiv_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [4:0] opcode;
    logic [4:0] aluOp;
    logic       isMd;
    logic       unusedIrBits;

    assign opcode       = ir_x[31:27];
    assign aluOp        = ir_x[6:2];
    assign isMd         = valid_x && (opcode == 5'b00000) && (aluOp == ALU_MUL || aluOp == ALU_DIV);
    assign unusedIrBits = ^{ir_x[21:7], ir_x[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            isDiv_q  <= 1'b0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            isDiv_q  <= isDiv_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        isDiv_d   = isDiv_q;
        rd_d      = rd_q;
        result_d  = result_q;
        exc_d     = exc_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;

        case (state_q)
            IDLE: begin
                stall = isMd && !flush;
                if (isMd && !flush) begin
                    state_d = START;
                    isDiv_d = (aluOp == ALU_DIV);
                    rd_d    = ir_x[26:22];
                end
            end
            START: begin
                stall     = 1'b1;
                ctrl_MULT = !isDiv_q;
                ctrl_DIV  = isDiv_q;
                cnt_d     = 8'd0;
                exc_d     = 1'b0;
                tmo_d     = 1'b0;
                state_d   = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                // A result arriving on the last allowed cycle still beats the timeout.
                if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (tmo_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = RSTATUS;
                    wb_data  = 32'(EXC_TMO);
                end else if (exc_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = RSTATUS;
                    wb_data  = isDiv_q ? 32'(EXC_DIV) : 32'(EXC_MUL);
                end else begin
                    wb_valid = (rd_q != 5'd0);
                    wb_rd    = rd_q;
                    wb_data  = result_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush kills the op; the unit itself keeps running until the next start.
        if (flush) begin
            state_d   = IDLE;
            result_d  = 32'd0;
            exc_d     = 1'b0;
            tmo_d     = 1'b0;
            cnt_d     = 8'd0;
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            stall     = 1'b0;
            wb_valid  = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: a driver issues mul/div ops and
// pushes predicted writebacks; a monitor pops them when wb_valid appears.
module tb_multdiv_sequencer;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ir_x;
    logic        valid_x;
    logic        flush;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t expQ[$];
    wb_t monExp;

    multdiv_sequencer #(
        .TIMEOUT(TMO),
        .EXC_MUL(4),
        .EXC_DIV(5),
        .EXC_TMO(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ir_x(ir_x),
        .valid_x(valid_x),
        .flush(flush),
        .md_ready(md_ready),
        .md_result(md_result),
        .md_exception(md_exception),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .stall(stall),
        .busy(busy),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl_MULT"}, 32'(ctrl_MULT), 0);
        checkOutput({tag, "_ctrl_DIV"}, 32'(ctrl_DIV), 0);
        checkOutput({tag, "_stall"}, 32'(stall), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 0);
        checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 0);
        checkOutput({tag, "_wb_data"}, wb_data, 0);
    endtask

    // Monitor: every writeback the DUT presents must match the oldest prediction.
    always @(negedge clock) begin
        if (reset === 1'b0 && wb_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb actual rd=%0d data=%h required none", wb_rd, wb_data);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wb_rd", 32'(wb_rd), 32'(monExp.rd));
                checkOutput("wb_data", wb_data, monExp.data);
            end
        end
    end

    // Reference model: outcome decided purely by when the unit answers and what it says.
    function automatic int predict(input bit isDiv, input logic [4:0] rd, input int readyWait,
                                   input logic [31:0] res, input bit exc);
        wb_t e;
        bit  timedOut;
        timedOut = (readyWait < 1) || (readyWait > TMO);
        if (timedOut) begin
            e.rd = 5'd30; e.data = 32'd6; expQ.push_back(e);
        end else if (exc) begin
            e.rd = 5'd30; e.data = isDiv ? 32'd5 : 32'd4; expQ.push_back(e);
        end else if (rd != 5'd0) begin
            e.rd = rd; e.data = res; expQ.push_back(e);
        end
        return timedOut ? TMO + 2 : readyWait + 2;
    endfunction

    function automatic logic [31:0] mdInstr(input bit isDiv, input logic [4:0] rd);
        logic [31:0] junk;
        junk = $urandom;
        return {5'b00000, rd, junk[14:0], (isDiv ? 5'b00111 : 5'b00110), junk[16:15]};
    endfunction

    // Drives one op; readyWait is the WAIT cycle (1-based) carrying md_ready, 0 = never.
    task automatic applyStimulus(input bit isDiv, input logic [4:0] rd, input int readyWait,
                                 input logic [31:0] res, input bit exc);
        int stallExp;
        int stallCnt = 0;
        int pulseCnt = 0;
        int c = 0;
        bit done = 0;
        stallExp = predict(isDiv, rd, readyWait, res, exc);
        ir_x = mdInstr(isDiv, rd);
        valid_x = 1'b1;
        while (!done && c < TMO + 6) begin
            if (c == 1) begin
                md_ready = 1'($urandom_range(0, 1));
                md_result = $urandom;
                md_exception = 1'($urandom_range(0, 1));
            end else if (readyWait > 0 && c == readyWait + 1) begin
                md_ready = 1'b1;
                md_result = res;
                md_exception = exc;
            end else begin
                md_ready = 1'b0;
                md_result = $urandom;
                md_exception = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            if (c == 0) checkOutput("decode_busy", 32'(busy), 0);
            if (c == 1) begin
                checkOutput("start_mult", 32'(ctrl_MULT), 32'(!isDiv));
                checkOutput("start_div", 32'(ctrl_DIV), 32'(isDiv));
            end
            if (stall) stallCnt++;
            if (ctrl_MULT || ctrl_DIV) pulseCnt++;
            if (!stall) done = 1;
            @(posedge clock);
            #1;
            c++;
        end
        checkOutput("op_completed", 32'(done), 1);
        checkOutput("stall_cycles", 32'(stallCnt), 32'(stallExp));
        checkOutput("start_pulses", 32'(pulseCnt), 1);
        md_ready = 1'b0;
        valid_x = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ir_x = 32'd0;
        valid_x = 1'b0;
        flush = 1'b0;
        md_ready = 1'b0;
        md_result = 32'd0;
        md_exception = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed cases from the test plan.
        applyStimulus(1'b0, 5'd5, 3, 32'h0000_0C35, 1'b0);
        applyStimulus(1'b1, 5'd12, 2, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b0, 5'd12, 1, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, 5'd3, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd4, TMO, 32'hCAFE_0001, 1'b0);
        applyStimulus(1'b0, 5'd0, 2, 32'h5555_AAAA, 1'b0);
        applyStimulus(1'b0, 5'd0, 1, 32'h0, 1'b1);
        applyStimulus(1'b0, 5'd10, 1, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, 5'd11, 1, 32'h0000_0002, 1'b0);

        // Flush while waiting: nothing written back, late md_ready ignored.
        ir_x = mdInstr(1'b0, 5'd7);
        valid_x = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_stall", 32'(stall), 0);
        checkOutput("flush_wb_valid", 32'(wb_valid), 0);
        checkOutput("flush_ctrl", 32'(ctrl_MULT | ctrl_DIV), 0);
        checkOutput("flush_busy_wait", 32'(busy), 1);
        @(posedge clock); #1;
        flush = 1'b0;
        valid_x = 1'b0;
        md_ready = 1'b1;
        md_result = 32'h7777_7777;
        md_exception = 1'b0;
        @(negedge clock);
        checkOutput("postflush_busy", 32'(busy), 0);
        checkOutput("postflush_stall", 32'(stall), 0);
        @(posedge clock); #1;
        md_ready = 1'b0;
        @(negedge clock);
        checkOutput("postflush_wb_valid", 32'(wb_valid), 0);
        @(posedge clock); #1;
        applyStimulus(1'b0, 5'd7, 2, 32'h0BAD_F00D, 1'b0);

        // Flush on the decode cycle keeps the sequencer idle.
        ir_x = mdInstr(1'b1, 5'd8);
        valid_x = 1'b1;
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_idle_stall", 32'(stall), 0);
        @(posedge clock); #1;
        flush = 1'b0;
        valid_x = 1'b0;
        @(negedge clock);
        checkOutput("flush_idle_busy", 32'(busy), 0);
        @(posedge clock); #1;

        // Asynchronous reset in the middle of WAIT.
        ir_x = mdInstr(1'b1, 5'd9);
        valid_x = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset = 1'b1;
        valid_x = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        md_ready = 1'b1;
        md_result = 32'h1111_2222;
        md_exception = 1'b0;
        @(negedge clock);
        checkOutput("postreset_busy", 32'(busy), 0);
        checkOutput("postreset_wb_valid", 32'(wb_valid), 0);
        @(posedge clock); #1;
        md_ready = 1'b0;
        @(negedge clock);
        checkOutput("postreset_wb_valid2", 32'(wb_valid), 0);
        @(posedge clock); #1;

        // Non-md instructions must never stall.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (i < 4) ir_x = {5'b00000, r[26:7], 5'b00000, r[1:0]};
            else ir_x = {5'b00001 + 5'(i), r[26:7], 5'b00110, r[1:0]};
            valid_x = 1'b1;
            md_ready = r[31];
            @(negedge clock);
            checkOutput("non_md_stall", 32'(stall), 0);
            @(posedge clock); #1;
            checkOutput("non_md_busy", 32'(busy), 0);
        end
        valid_x = 1'b0;
        md_ready = 1'b0;

        // Randomized ops, mostly back-to-back.
        for (int i = 0; i < 40; i++) begin
            bit          isDiv;
            logic [4:0]  rd;
            int          rw;
            logic [31:0] res;
            bit          exc;
            isDiv = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rw = $urandom_range(0, TMO + 2);
            res = $urandom;
            exc = ($urandom_range(0, 3) == 0);
            applyStimulus(isDiv, rd, rw, res, exc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end

        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the shared multi-cycle multiply/divide unit for the execute stage. Decodes an ALU-class mul/div instruction in X, issues a one-cycle start pulse, and holds the F/D/X pipeline stalled until the unit reports a result. Converts the result or exception into a single-cycle writeback request: the destination register, or r30 (rstatus) with an exception code. Sits between the X-stage instruction register, the multdiv unit and the writeback mux.

## Interface
Parameters:
- TIMEOUT, 64: maximum WAIT cycles before the op is abandoned; legal range 2..255.
- EXC_MUL, 4: rstatus code written on multiply overflow.
- EXC_DIV, 5: rstatus code written on divide-by-zero.
- EXC_TMO, 6: rstatus code written on timeout.

Ports:
- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- ir_x  in  32  instruction in X; opcode ir_x[31:27], rd ir_x[26:22], alu_op ir_x[6:2].
- valid_x  in  1  ir_x holds a real (non-bubble) instruction.
- flush  in  1  synchronous kill of the X-stage instruction and any in-flight op.
- md_ready  in  1  multdiv unit result valid (data_resultRDY).
- md_result  in  32  multdiv unit result.
- md_exception  in  1  multdiv unit exception, qualified by md_ready.
- ctrl_MULT  out  1  registered one-cycle start pulse, multiply.
- ctrl_DIV  out  1  registered one-cycle start pulse, divide.
- stall  out  1  freeze F/D/X latches.
- busy  out  1  state is not IDLE.
- wb_valid  out  1  one-cycle writeback request.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.

## Operation
- Decode: is_md = valid_x & (opcode==5'b00000) & (alu_op==5'b00110 (mul) | alu_op==5'b00111 (div)).
- IDLE:
  - If is_md & !flush: latch is_div, rd = ir_x[26:22]; go to START.
  - stall = is_md & !flush, combinational.
- START:
  - ctrl_MULT or ctrl_DIV = 1 for exactly this cycle; stall = 1.
  - Clear the wait counter; md_ready is ignored; go to WAIT.
- WAIT:
  - stall = 1; the counter increments each cycle.
  - md_ready = 1: capture md_result and md_exception; go to DONE.
  - Else, counter == TIMEOUT-1: set the timeout flag; go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE:
  - stall = 0; wb_valid = 1 for one cycle; go to IDLE. X advances at this edge.
  - No exception: wb_rd = latched rd; wb_data = captured result.
  - md_exception: wb_rd = 30; wb_data = EXC_DIV if div, else EXC_MUL.
  - Timeout: wb_rd = 30; wb_data = EXC_TMO.
  - No exception and rd == 0: wb_valid is suppressed.
- flush, any state: next state IDLE; ctrl pulses, stall and wb_valid are 0 in that cycle; captured data is discarded.
  - An abandoned unit op is not stopped; the next start pulse restarts the unit.
- Outputs outside DONE: wb_valid, wb_rd and wb_data = 0.

## Timing
- Reset: state IDLE; ctrl_MULT, ctrl_DIV, busy, wb_valid, wb_rd, wb_data = 0. stall = 0 unless the IDLE decode condition holds.
- Cycle 0 (IDLE, decode): stall = 1.
- Cycle 1 (START): ctrl pulse.
- Cycle 2..: WAIT.
- md_ready high in cycle k produces wb_valid in cycle k+1.
- Minimum occupancy is 4 cycles (md_ready in the first WAIT cycle).
- Maximum occupancy is TIMEOUT+3 cycles.
- Back-to-back mul/div: the DONE edge loads the next instruction into X; the next IDLE cycle decodes it. No idle gap beyond that one cycle.
- stall is combinational from ir_x/valid_x/flush in IDLE only; it is registered-state-derived in all other states.

## Test plan
- mul rd=5, md_ready 3 cycles after ctrl_MULT with result 0x0000_0C35 -> stall for 5 cycles, ctrl_MULT high exactly 1 cycle, wb_valid with rd=5, data=0x0000_0C35, then IDLE.
- div with md_exception=1 at md_ready -> wb_rd=30, wb_data=5; the same case as mul -> wb_data=4.
- md_ready never asserted, TIMEOUT=8 -> after 8 WAIT cycles wb_rd=30, wb_data=6; total stall 10 cycles.
- flush asserted in WAIT, then md_ready next cycle -> no wb_valid, stall=0 from the flush cycle, state IDLE; a subsequent mul issues normally.
- Two consecutive mul instructions -> two ctrl_MULT pulses, two wb_valid pulses with correct rd each, one IDLE cycle between them.
- reset asserted mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately; md_ready after release is ignored; non-md ALU op (alu_op=00000) never raises stall.
